// File: rtl/mrv1_pkg.sv
// Shared core types: writeback request payload and writeback source indices.
package mrv1_pkg;

  localparam int MRV1_DATA_W = 32;
  localparam int MRV1_TID_W  = 3;
  localparam int MRV1_ADDR_W = 5;

  typedef struct packed {
    logic [MRV1_TID_W-1:0]  tid;
    logic [MRV1_ADDR_W-1:0] addr;
    logic [MRV1_DATA_W-1:0] data;
  } wb_req_t;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_MUL = 1;
  localparam int WB_SRC_LSU = 2;

endpackage

// File: rtl/mrv1_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, then
// moves the pointer just past the winner.
module mrv1_rr_arb #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N works.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (IW+1)'(off);
      idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      ptr <= '0;
    else if (found)
      ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/mrv1_wb_arb.sv
// Writeback arbiter: picks one execution-unit result per cycle and registers it
// onto the RF write port together with a scoreboard-clear pulse.
module mrv1_wb_arb
  import mrv1_pkg::*;
#(
  parameter int DATA_WIDTH_P    = 32,
  parameter int NUM_THREADS_P   = 8,
  parameter int rf_addr_width_p = 5,
  parameter int NUM_SRC_P       = 3,
  parameter int TID_WIDTH_LP    = $clog2(NUM_THREADS_P),
  parameter int SRC_ID_WIDTH_LP = $clog2(NUM_SRC_P)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          hold_i,
  input  logic [NUM_SRC_P-1:0]                          src_valid_i,
  output logic [NUM_SRC_P-1:0]                          src_ready_o,
  input  logic [NUM_SRC_P-1:0][TID_WIDTH_LP-1:0]        src_tid_i,
  input  logic [NUM_SRC_P-1:0][rf_addr_width_p-1:0]     src_addr_i,
  input  logic [NUM_SRC_P-1:0][DATA_WIDTH_P-1:0]        src_data_i,
  output logic                                          rd_w_en_o,
  output logic [TID_WIDTH_LP-1:0]                       rd_tid_o,
  output logic [rf_addr_width_p-1:0]                    rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]                       rd_data_o,
  output logic                                          sb_clr_o,
  output logic [TID_WIDTH_LP-1:0]                       sb_clr_tid_o,
  output logic [rf_addr_width_p-1:0]                    sb_clr_addr_o,
  output logic [SRC_ID_WIDTH_LP-1:0]                    grant_src_o
);

  typedef struct packed {
    logic [TID_WIDTH_LP-1:0]    tid;
    logic [rf_addr_width_p-1:0] addr;
    logic [DATA_WIDTH_P-1:0]    data;
  } req_t;

  logic [NUM_SRC_P-1:0]       gnt;
  logic [SRC_ID_WIDTH_LP-1:0] gnt_idx;
  logic                       any_gnt;
  req_t                       sel;
  req_t                       out_q;

  mrv1_rr_arb #(.N(NUM_SRC_P)) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (src_valid_i),
    .en      (rst_i && !hold_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign src_ready_o = gnt;
  assign any_gnt     = |gnt;

  always_comb begin
    sel.tid  = src_tid_i[gnt_idx];
    sel.addr = src_addr_i[gnt_idx];
    sel.data = src_data_i[gnt_idx];
  end

  // Payload holds when idle; only the enables pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_w_en_o   <= 1'b0;
      sb_clr_o    <= 1'b0;
      out_q       <= '0;
      grant_src_o <= '0;
    end else begin
      rd_w_en_o <= any_gnt && (sel.addr != '0);
      sb_clr_o  <= any_gnt;
      if (any_gnt) begin
        out_q       <= sel;
        grant_src_o <= gnt_idx;
      end
    end
  end

  assign rd_tid_o      = out_q.tid;
  assign rd_addr_o     = out_q.addr;
  assign rd_data_o     = out_q.data;
  assign sb_clr_tid_o  = out_q.tid;
  assign sb_clr_addr_o = out_q.addr;

endmodule

// File: doc/mrv1_wb_arb.md
Name: mrv1_wb_arb

Overview:
Writeback arbiter for the multithreaded core. It collects results from NUM_SRC_P execution units (default: ALU, MUL/DIV, LSU), each tagged with a thread id and destination register. Each cycle it grants at most one source by round-robin and registers the winner onto the register-file write port (rd_tid/rd_w_en/rd_addr/rd_data). It also emits a matching scoreboard-clear pulse.

Parameters:
DATA_WIDTH_P, 32, result data width
NUM_THREADS_P, 8, hardware threads
rf_addr_width_p, 5, architectural register index width
NUM_SRC_P, 3, number of writeback sources (must be >= 2)
TID_WIDTH_LP, $clog2(NUM_THREADS_P), thread id width (derived)
SRC_ID_WIDTH_LP, $clog2(NUM_SRC_P), source index width (derived)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset; synchronous, active-low
hold_i  in  1  when 1, no grants this cycle
src_valid_i  in  NUM_SRC_P  per-source result valid
src_ready_o  out  NUM_SRC_P  per-source accept (one-hot or zero)
src_tid_i  in  NUM_SRC_P x TID_WIDTH_LP  per-source thread id
src_addr_i  in  NUM_SRC_P x rf_addr_width_p  per-source destination register
src_data_i  in  NUM_SRC_P x DATA_WIDTH_P  per-source result
rd_w_en_o  out  1  RF write enable
rd_tid_o  out  TID_WIDTH_LP  RF write thread id
rd_addr_o  out  rf_addr_width_p  RF write register
rd_data_o  out  DATA_WIDTH_P  RF write data
sb_clr_o  out  1  scoreboard clear pulse
sb_clr_tid_o  out  TID_WIDTH_LP  thread to clear
sb_clr_addr_o  out  rf_addr_width_p  register to clear
grant_src_o  out  SRC_ID_WIDTH_LP  source index of the current output (debug/perf)

Behaviour:
- Handshake: a transfer occurs on source i when src_valid_i[i] && src_ready_o[i]. src_ready_o is combinational from src_valid_i, the RR pointer, hold_i and reset. A source must hold valid and payload stable until accepted and must not make valid depend on ready.
- Grant: if hold_i=1 or rst_i=0, src_ready_o=0. Otherwise grant the first valid source scanning ptr, ptr+1, ..., wrapping modulo NUM_SRC_P. src_ready_o is one-hot on that source, or zero if no source is valid.
- RR pointer: resets to 0. After a grant to source k, ptr <= (k+1) mod NUM_SRC_P (wraps from NUM_SRC_P-1 to 0). Unchanged when there is no grant.
- Output stage: a single register with latency 1. The cycle after a grant: sb_clr_o=1 and rd_tid_o/rd_addr_o/rd_data_o/sb_clr_tid_o/sb_clr_addr_o/grant_src_o carry the granted payload.
  - rd_w_en_o=1 only if the granted addr != 0. For an x0 destination, rd_w_en_o=0 but sb_clr_o=1.
  - No grant: rd_w_en_o=0 and sb_clr_o=0 next cycle; payload outputs hold their previous values.
- Throughput: one result per cycle. No backpressure from the RF (always writes).
- Reset (rst_i=0 at an edge): rd_w_en_o=0, sb_clr_o=0, all payload outputs 0, grant_src_o=0, ptr=0. No grant is issued in the reset cycle, and an output pending from the previous cycle is dropped.
- Simultaneous valid from all sources with fixed payloads: each source is granted exactly once per NUM_SRC_P cycles (no starvation).
- hold_i toggling does not move ptr.

Decomposition:
- mrv1_pkg gains a wb_req_t struct {tid, addr, data} and the source-index constants WB_SRC_ALU=0, WB_SRC_MUL=1, WB_SRC_LSU=2.
- Sub-module mrv1_rr_arb (parameter N; inputs req, en; outputs one-hot gnt and encoded gnt_idx; owns the pointer) is instantiated once. Payload mux and output register live in mrv1_wb_arb.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with all src_valid_i=1 -> src_ready_o=0, rd_w_en_o=0, sb_clr_o=0. First cycle after release grants source 0.
- Single source: src1 valid, tid=3, addr=7, data=0xDEADBEEF -> ready[1]=1 same cycle. Next cycle rd_w_en_o=1, rd_tid_o=3, rd_addr_o=7, rd_data_o=0xDEADBEEF, sb_clr_o=1, grant_src_o=1.
- Round-robin: all 3 sources continuously valid for 6 cycles -> grant order 0,1,2,0,1,2; one write per cycle.
- Pointer wrap/skip: ptr=2, only src0 and src1 valid -> src0 granted, then src1.
- x0 destination: src0 addr=0, tid=5 -> next cycle rd_w_en_o=0, sb_clr_o=1, sb_clr_tid_o=5, sb_clr_addr_o=0.
- hold_i and reset mid-flow: hold_i=1 for 3 cycles with all valid -> no ready, no writes, ptr unchanged. Then reset asserted one cycle after a grant -> the pending write is not seen (rd_w_en_o=0).
